period_timer: RTL and testbench

//   Programmable period counter; drives the A_i side of a comparatorEqual stage.
//   The comparator's B_i side is the latched period. Its match output ends each count interval.

---
 rtl/period_timer_pkg.sv | 17 +
 rtl/comparatorEqual.sv | 16 +
 rtl/period_timer.sv | 116 +++++++++++
 tb/tb_period_timer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/period_timer_pkg.sv
// ==== period_timer_pkg : shared FSM encoding and mode constants ==== rev 1.0 ====
`default_nettype none

package period_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } timer_state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/comparatorEqual.sv
// ==== comparatorEqual : combinational A == B equality detector ==== rev 1.0 ====
`default_nettype none

module comparatorEqual #(
  parameter int DATA_WIDTH = 13
) (
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  A_equal_B_o
);

  assign A_equal_B_o = (A_i == B_i);

endmodule

`default_nettype wire

// File: rtl/period_timer.sv
// ==== period_timer : programmable period counter, one-shot / auto-reload tick ==== rev 1.0 ====
`default_nettype none

module period_timer
  import period_timer_pkg::*;
#(
  parameter int DATA_WIDTH = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] period_i,
  output logic [DATA_WIDTH-1:0] count_o,
  output logic                  busy_o,
  output logic                  tick_o,
  output logic                  done_o
);

  localparam logic [DATA_WIDTH-1:0] c_one  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] c_zero = '0;

  timer_state_e          r_state, w_state_nx;
  logic [DATA_WIDTH-1:0] r_count, w_count_nx;
  logic [DATA_WIDTH-1:0] r_period, w_period_nx;
  logic                  r_mode, w_mode_nx;
  logic                  r_tick, w_tick_nx;
  logic                  r_done, w_done_nx;
  logic                  w_match;

  comparatorEqual #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp_terminal (
    .A_i         (r_count),
    .B_i         (r_period),
    .A_equal_B_o (w_match)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_count_nx  = r_count;
    w_period_nx = r_period;
    w_mode_nx   = r_mode;
    w_tick_nx   = 1'b0;
    w_done_nx   = r_done;
    case (r_state)
      IDLE, DONE: begin
        if (stop_i) begin
          w_state_nx = IDLE;
          w_count_nx = c_zero;
          w_done_nx  = 1'b0;
        end else if (start_i) begin
          w_state_nx  = RUN;
          w_period_nx = period_i;
          w_mode_nx   = mode_i;
          w_count_nx  = c_zero;
          w_done_nx   = 1'b0;
        end
      end
      RUN: begin
        if (stop_i) begin
          w_state_nx = IDLE;
          w_count_nx = c_zero;
        end else if (start_i) begin
          w_period_nx = period_i;
          w_mode_nx   = mode_i;
          w_count_nx  = c_zero;
        end else if (w_match) begin
          w_tick_nx  = 1'b1;
          w_count_nx = c_zero;
          if (r_mode == MODE_ONESHOT) begin
            w_state_nx = DONE;
            w_done_nx  = 1'b1;
          end else begin
            // reload picks up the new period only at the wrap boundary
            w_period_nx = period_i;
          end
        end else begin
          w_count_nx = r_count + c_one;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_count_nx = c_zero;
        w_done_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_count  <= c_zero;
      r_period <= c_zero;
      r_mode   <= MODE_ONESHOT;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_count  <= w_count_nx;
      r_period <= w_period_nx;
      r_mode   <= w_mode_nx;
      r_tick   <= w_tick_nx;
      r_done   <= w_done_nx;
    end
  end

  assign count_o = r_count;
  assign busy_o  = (r_state == RUN);
  assign tick_o  = r_tick;
  assign done_o  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_period_timer.sv
// ==== tb_period_timer : scoreboard bench for period_timer ==== rev 1.0 ====
`default_nettype none

module tb_period_timer;

  localparam int DATA_WIDTH = 13;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  stop;
  logic                  mode;
  logic [DATA_WIDTH-1:0] period;
  logic [DATA_WIDTH-1:0] count;
  logic                  busy;
  logic                  tick;
  logic                  done;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  // scoreboard: expected {count, busy, tick, done} after a given edge
  int          q_cyc[$];
  string       q_tag[$];
  logic [15:0] q_exp[$];

  period_timer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .stop_i   (stop),
    .mode_i   (mode),
    .period_i (period),
    .count_o  (count),
    .busy_o   (busy),
    .tick_o   (tick),
    .done_o   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got cnt=%0d busy=%0b tick=%0b done=%0b, want cnt=%0d busy=%0b tick=%0b done=%0b",
               tag, edge_cnt, got[15:3], got[2], got[1], got[0], exp[15:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic exp_at(input int e, input string tag, input int cnt,
                        input bit b, input bit t, input bit d);
    logic [12:0] c;
    c = cnt[12:0];
    q_cyc.push_back(e);
    q_tag.push_back(tag);
    q_exp.push_back({c, b, t, d});
  endtask

  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= edge_cnt) begin
      check_val(q_tag[0], {count, busy, tick, done}, q_exp[0]);
      void'(q_cyc.pop_front());
      void'(q_tag.pop_front());
      void'(q_exp.pop_front());
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; period = '0;
    go(2);
    exp_at(edge_cnt, "reset_state", 0, 0, 0, 0);
    rst_n = 1'b1;
    go(1);

    // 1: reset mid-run at count 4
    e0 = edge_cnt + 1;
    for (int k = 0; k <= 4; k++) exp_at(e0 + k, "rst_run", k, 1, 0, 0);
    exp_at(e0 + 5, "rst_hit", 0, 0, 0, 0);
    exp_at(e0 + 6, "rst_idle", 0, 0, 0, 0);
    start = 1'b1; period = 13'd10; mode = 1'b0;
    go(1); start = 1'b0;
    go(4); rst_n = 1'b0;
    go(1); rst_n = 1'b1;
    go(2);

    // 2: one-shot N=5
    e0 = edge_cnt + 1;
    for (int k = 0; k <= 5; k++) exp_at(e0 + k, "os_count", k, 1, 0, 0);
    exp_at(e0 + 6, "os_tick", 0, 0, 1, 1);
    for (int k = 7; k <= 9; k++) exp_at(e0 + k, "os_done_hold", 0, 0, 0, 1);
    start = 1'b1; period = 13'd5; mode = 1'b0;
    go(1); start = 1'b0;
    go(9);

    // 6: DONE -> start N=2, then stop from DONE
    e0 = edge_cnt + 1;
    for (int k = 0; k <= 2; k++) exp_at(e0 + k, "done_restart", k, 1, 0, 0);
    exp_at(e0 + 3, "done_restart_tick", 0, 0, 1, 1);
    exp_at(e0 + 4, "done_again", 0, 0, 0, 1);
    exp_at(e0 + 5, "done_stop", 0, 0, 0, 0);
    exp_at(e0 + 6, "done_stop_idle", 0, 0, 0, 0);
    start = 1'b1; period = 13'd2;
    go(1); start = 1'b0;
    go(4); stop = 1'b1;
    go(1); stop = 1'b0;
    go(1);

    // 3: auto-reload N=3, period changed to 1 mid-interval
    e0 = edge_cnt + 1;
    for (int k = 0; k <= 7; k++) exp_at(e0 + k, "ar3", k % 4, 1, (k == 4), 0);
    for (int k = 8; k <= 12; k++) exp_at(e0 + k, "ar1", (k - 8) % 2, 1, ((k - 8) % 2 == 0), 0);
    exp_at(e0 + 13, "ar_stop", 0, 0, 0, 0);
    start = 1'b1; period = 13'd3; mode = 1'b1;
    go(1); start = 1'b0;
    go(5); period = 13'd1;
    go(7); stop = 1'b1;
    go(1); stop = 1'b0;

    // 4a: auto-reload N=0 ticks every cycle from E1
    e0 = edge_cnt + 1;
    exp_at(e0, "ar0_start", 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) exp_at(e0 + k, "ar0_tick", 0, 1, 1, 0);
    exp_at(e0 + 6, "ar0_stop", 0, 0, 0, 0);
    start = 1'b1; period = 13'd0; mode = 1'b1;
    go(1); start = 1'b0;
    go(5); stop = 1'b1;
    go(1); stop = 1'b0;

    // 4b: full-range period 8191
    e0 = edge_cnt + 1;
    exp_at(e0, "max_start", 0, 1, 0, 0);
    exp_at(e0 + 1, "max_one", 1, 1, 0, 0);
    exp_at(e0 + 8191, "max_top", 8191, 1, 0, 0);
    exp_at(e0 + 8192, "max_wrap", 0, 1, 1, 0);
    exp_at(e0 + 8193, "max_after", 1, 1, 0, 0);
    exp_at(e0 + 8194, "max_stop", 0, 0, 0, 0);
    start = 1'b1; period = 13'h1FFF; mode = 1'b1;
    go(1); start = 1'b0;
    go(8193); stop = 1'b1;
    go(1); stop = 1'b0;

    // 5a: stop on the match cycle suppresses tick and done
    e0 = edge_cnt + 1;
    for (int k = 0; k <= 3; k++) exp_at(e0 + k, "stopm_count", k, 1, 0, 0);
    exp_at(e0 + 4, "stopm_stop", 0, 0, 0, 0);
    exp_at(e0 + 5, "stopm_idle", 0, 0, 0, 0);
    start = 1'b1; period = 13'd3; mode = 1'b0;
    go(1); start = 1'b0;
    go(3); stop = 1'b1;
    go(1); stop = 1'b0;
    go(1);

    // 5b: start and stop together in IDLE
    e0 = edge_cnt + 1;
    exp_at(e0, "ss_idle", 0, 0, 0, 0);
    exp_at(e0 + 1, "ss_idle2", 0, 0, 0, 0);
    start = 1'b1; stop = 1'b1; period = 13'd4;
    go(1); start = 1'b0; stop = 1'b0;
    go(1);

    // 5c: restart at count 2 relatches a shorter period
    e0 = edge_cnt + 1;
    for (int k = 0; k <= 2; k++) exp_at(e0 + k, "rs_first", k, 1, 0, 0);
    for (int k = 0; k <= 2; k++) exp_at(e0 + 3 + k, "rs_second", k, 1, 0, 0);
    exp_at(e0 + 6, "rs_tick", 0, 0, 1, 1);
    start = 1'b1; period = 13'd5; mode = 1'b0;
    go(1); start = 1'b0;
    go(2); start = 1'b1; period = 13'd2;
    go(1); start = 1'b0; period = 13'd7;
    go(4);

    go(2);
    check_val("sb_drain", 16'(q_cyc.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
